// File: rtl/maxpool_relu_pkg.sv
// Shared constants and sample type for the conv1 -> conv2 max-pool/ReLU stage.
package maxpool_relu_pkg;
    localparam int unsigned CONV_BIT    = 12;
    localparam int unsigned CHANNEL_LEN = 3;
    localparam int unsigned POOL_SIZE   = 2;
    localparam int unsigned IN_WIDTH    = 24;
    localparam int unsigned IN_HEIGHT   = 24;

    typedef logic signed [CONV_BIT-1:0] sample_t;
endpackage

// File: rtl/maxpool_relu_pool_channel.sv
// One channel of 2x2 max pooling: holds the even-column pixel and a half-row of
// partial maxima, then emits the ReLU'd window maximum on the bottom-right pixel.
module pool_channel #(
    parameter int unsigned CONV_BIT   = 12,
    parameter int unsigned HALF_WIDTH = 12,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       accept,
    input  logic                       col_is_odd,
    input  logic                       row_is_odd,
    input  logic [IDX_W-1:0]           pbuf_idx,
    input  logic signed [CONV_BIT-1:0] din,
    output logic signed [CONV_BIT-1:0] dout
);
    logic signed [CONV_BIT-1:0] hold;
    logic signed [CONV_BIT-1:0] pbuf [HALF_WIDTH];
    logic signed [CONV_BIT-1:0] pair_max_c;
    logic signed [CONV_BIT-1:0] quad_max_c;

    function automatic logic signed [CONV_BIT-1:0] smax(
        input logic signed [CONV_BIT-1:0] a,
        input logic signed [CONV_BIT-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    assign pair_max_c = smax(hold, din);
    assign quad_max_c = smax(pbuf[pbuf_idx], pair_max_c);

    // Hold register and pooled output; negative window maxima clamp to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
            dout <= '0;
        end else if (accept) begin
            if (!col_is_odd) begin
                hold <= din;
            end else if (row_is_odd) begin
                dout <= quad_max_c[CONV_BIT-1] ? '0 : quad_max_c;
            end
        end
    end

    // Every entry is rewritten on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (accept && col_is_odd && !row_is_odd) begin
            pbuf[pbuf_idx] <= pair_max_c;
        end
    end
endmodule

// File: rtl/maxpool_relu.sv
// 2x2 stride-2 max pooling + ReLU over the 3-channel conv1 stream; shared
// raster counters drive one pool_channel per channel.
module maxpool_relu
    import maxpool_relu_pkg::*;
#(
    parameter int unsigned CONV_BIT  = maxpool_relu_pkg::CONV_BIT,
    parameter int unsigned IN_WIDTH  = maxpool_relu_pkg::IN_WIDTH,
    parameter int unsigned IN_HEIGHT = maxpool_relu_pkg::IN_HEIGHT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic signed [CONV_BIT-1:0] conv_out_1,
    input  logic signed [CONV_BIT-1:0] conv_out_2,
    input  logic signed [CONV_BIT-1:0] conv_out_3,
    output logic signed [CONV_BIT-1:0] max_value_1,
    output logic signed [CONV_BIT-1:0] max_value_2,
    output logic signed [CONV_BIT-1:0] max_value_3,
    output logic                       valid_out
);
    localparam int unsigned HALF_WIDTH = IN_WIDTH / POOL_SIZE;
    localparam int unsigned COL_W      = $clog2(IN_WIDTH);
    localparam int unsigned ROW_W      = $clog2(IN_HEIGHT);
    localparam int unsigned IDX_W      = COL_W - 1;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic signed [CONV_BIT-1:0] din  [CHANNEL_LEN];
    logic signed [CONV_BIT-1:0] dout [CHANNEL_LEN];

    assign din[0]      = conv_out_1;
    assign din[1]      = conv_out_2;
    assign din[2]      = conv_out_3;
    assign max_value_1 = dout[0];
    assign max_value_2 = dout[1];
    assign max_value_3 = dout[2];

    // Raster position; frozen while valid_in is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col == COL_W'(IN_WIDTH - 1)) begin
                col <= '0;
                row <= (row == ROW_W'(IN_HEIGHT - 1)) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Strobe once per completed window (bottom-right pixel accepted).
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in & col[0] & row[0];
        end
    end

    for (genvar c = 0; c < CHANNEL_LEN; c++) begin : g_ch
        pool_channel #(
            .CONV_BIT  (CONV_BIT),
            .HALF_WIDTH(HALF_WIDTH),
            .IDX_W     (IDX_W)
        ) u_pool (
            .clk       (clk),
            .rst       (rst),
            .accept    (valid_in),
            .col_is_odd(col[0]),
            .row_is_odd(row[0]),
            .pbuf_idx  (col[COL_W-1:1]),
            .din       (din[c]),
            .dout      (dout[c])
        );
    end
endmodule

// File: tb/tb_maxpool_relu.sv
// Directed bench for maxpool_relu: frame-level reference model feeds a scoreboard
// checked on every valid_out strobe.
module tb_maxpool_relu;
    import maxpool_relu_pkg::*;

    localparam int W = IN_WIDTH;
    localparam int H = IN_HEIGHT;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst;
    logic valid_in;
    logic signed [CONV_BIT-1:0] c1, c2, c3;
    logic signed [CONV_BIT-1:0] m1, m2, m3;
    logic valid_out;

    always #5 clk = ~clk;

    maxpool_relu dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .conv_out_1 (c1),
        .conv_out_2 (c2),
        .conv_out_3 (c3),
        .max_value_1(m1),
        .max_value_2(m2),
        .max_value_3(m3),
        .valid_out  (valid_out)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int in_cnt, pulses, first_idx, last_idx;
    int frame [3][N];
    int exp1 [$];
    int exp2 [$];
    int exp3 [$];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every strobe must follow an accepted beat and match the model.
    initial begin
        logic vin;
        int e;
        forever begin
            @(posedge clk);
            vin = valid_in;
            if (vin === 1'b1 && rst === 1'b0) in_cnt++;
            #1;
            if (valid_out === 1'b1) begin
                if (pulses == 0) first_idx = in_cnt - 1;
                last_idx = in_cnt - 1;
                pulses++;
                check("pulse_on_accept", int'(vin), 1);
                check("expect_pending", (exp1.size() > 0) ? 1 : 0, 1);
                if (exp1.size() > 0) begin
                    e = exp1.pop_front(); check("ch1", int'(m1), e);
                    e = exp2.pop_front(); check("ch2", int'(m2), e);
                    e = exp3.pop_front(); check("ch3", int'(m3), e);
                end
            end
        end
    end

    function automatic int relu_max4(input int ch, input int base);
        int m;
        m = frame[ch][base];
        if (frame[ch][base + 1] > m)     m = frame[ch][base + 1];
        if (frame[ch][base + W] > m)     m = frame[ch][base + W];
        if (frame[ch][base + W + 1] > m) m = frame[ch][base + W + 1];
        return (m < 0) ? 0 : m;
    endfunction

    task automatic push_expect();
        for (int wr = 0; wr < H / 2; wr++) begin
            for (int wc = 0; wc < W / 2; wc++) begin
                exp1.push_back(relu_max4(0, 2 * wr * W + 2 * wc));
                exp2.push_back(relu_max4(1, 2 * wr * W + 2 * wc));
                exp3.push_back(relu_max4(2, 2 * wr * W + 2 * wc));
            end
        end
    endtask

    task automatic fill(input int v1, input int v2, input int v3);
        for (int i = 0; i < N; i++) begin
            frame[0][i] = v1;
            frame[1][i] = v2;
            frame[2][i] = v3;
        end
    endtask

    task automatic send_range(input int lo, input int hi, input int gap_max);
        int g;
        for (int i = lo; i < hi; i++) begin
            valid_in = 1'b1;
            c1 = CONV_BIT'(frame[0][i]);
            c2 = CONV_BIT'(frame[1][i]);
            c3 = CONV_BIT'(frame[2][i]);
            @(posedge clk); #1;
            if (gap_max > 0) begin
                g = $urandom_range(0, gap_max);
                valid_in = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        valid_in = 1'b0;
        c1 = '0; c2 = '0; c3 = '0;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_valid_out", int'(valid_out), 0);
            check("rst_m1", int'(m1), 0);
            check("rst_m2", int'(m2), 0);
            check("rst_m3", int'(m3), 0);
        end
        rst = 1'b0;
        exp1.delete(); exp2.delete(); exp3.delete();
        in_cnt = 0;
        pulses = 0;
        first_idx = -1;
        last_idx = -1;
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0;
        c1 = '0; c2 = '0; c3 = '0;
        in_cnt = 0;
        pulses = 0;

        // 1: reset, then idle
        reset_dut();
        idle(20);
        check("idle_pulses", pulses, 0);

        // 2: constant frame, no gaps
        fill(5, 5, 5);
        push_expect();
        send_range(0, N, 0);
        idle(3);
        check("t2_pulses", pulses, 144);
        check("t2_first_idx", first_idx, 25);
        check("t2_last_idx", last_idx, 575);
        check("t2_queue_left", exp1.size(), 0);

        // 3: hand-computed first window
        reset_dut();
        fill(0, 0, 0);
        frame[0][0] = 3;     frame[0][1] = -7;   frame[0][W] = 10; frame[0][W + 1] = 2;
        frame[1][0] = -5;    frame[1][1] = -5;   frame[1][W] = -5; frame[1][W + 1] = -5;
        frame[2][0] = -2048; frame[2][1] = 2047; frame[2][W] = 0;  frame[2][W + 1] = -1;
        push_expect();
        send_range(0, W + 2, 0);
        check("t3_win0_ch1", int'(m1), 10);
        check("t3_win0_ch2", int'(m2), 0);
        check("t3_win0_ch3", int'(m3), 2047);
        send_range(W + 2, N, 0);
        idle(3);
        check("t3_pulses", pulses, 144);

        // 4: constant frame with random idle gaps
        reset_dut();
        fill(5, 5, 5);
        push_expect();
        send_range(0, N, 3);
        idle(3);
        check("t4_pulses", pulses, 144);
        check("t4_queue_left", exp1.size(), 0);

        // 5: partial frame, mid-frame reset, then ramp frame
        reset_dut();
        fill(7, 7, 7);
        for (int k = 0; k < 24; k++) begin
            exp1.push_back(7); exp2.push_back(7); exp3.push_back(7);
        end
        send_range(0, 100, 0);
        idle(2);
        check("t5_partial_pulses", pulses, 24);
        reset_dut();
        for (int i = 0; i < N; i++) begin
            frame[0][i] = i;
            frame[1][i] = -i;
            frame[2][i] = i - 300;
        end
        push_expect();
        send_range(0, W + 2, 0);
        check("t5_win0_ch1", int'(m1), 25);
        check("t5_win0_ch2", int'(m2), 0);
        send_range(W + 2, N, 0);
        idle(3);
        check("t5_pulses", pulses, 144);
        check("t5_first_idx", first_idx, 25);
        check("t5_last_m1", int'(m1), 575);

        // 6: back-to-back frames, no gap between them
        reset_dut();
        fill(100, 100, 100);
        push_expect();
        send_range(0, N, 0);
        fill(1, 1, 1);
        push_expect();
        send_range(0, N, 0);
        idle(3);
        check("t6_pulses", pulses, 288);
        check("t6_last_m1", int'(m1), 1);
        check("t6_queue_left", exp1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
